// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes, canonical NOP, fetch FSM encoding
// and the {instr, pc} packet passed from fetch to decode.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OPC_ARITH     = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pkt_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer between fetch and decode: holds the registered output
// packet plus one overflow entry, with same-edge drain and flush.
module fetch_skid_buf
  import rv32i_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  input  fetch_pkt_t in_pkt,
  input  logic       out_ready,
  output logic       out_valid,
  output fetch_pkt_t out_pkt,
  output logic       skid_full
);

  localparam fetch_pkt_t EMPTY_PKT = '{instr: NOP_INSTR, pc: 32'h0};

  logic       out_valid_q, out_valid_d;
  fetch_pkt_t out_pkt_q, out_pkt_d;
  logic       skid_valid_q, skid_valid_d;
  fetch_pkt_t skid_pkt_q, skid_pkt_d;
  logic       consume;

  assign consume = out_valid_q & out_ready;

  // NOTE: every target gets a default before any branch, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pkt_d    = out_pkt_q;
    skid_valid_d = skid_valid_q;
    skid_pkt_d   = skid_pkt_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      out_pkt_d    = EMPTY_PKT;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || consume) begin
      if (skid_valid_q) begin
        // Skid drains into out; a response arriving now refills the skid.
        out_valid_d  = 1'b1;
        out_pkt_d    = skid_pkt_q;
        skid_valid_d = in_valid;
        if (in_valid) skid_pkt_d = in_pkt;
      end else if (in_valid) begin
        out_valid_d = 1'b1;
        out_pkt_d   = in_pkt;
      end else begin
        out_valid_d = 1'b0;
        out_pkt_d   = EMPTY_PKT;
      end
    end else if (in_valid) begin
      skid_valid_d = 1'b1;
      skid_pkt_d   = in_pkt;
    end
  end

  // NOTE: non-blocking assignments for all state so every flop samples the
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_pkt_q    <= EMPTY_PKT;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pkt_q    <= out_pkt_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // NOTE: the skid payload has no reset; it is only ever read when
  // skid_valid_q is set, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    skid_pkt_q <= skid_pkt_d;
  end

  assign out_valid = out_valid_q;
  assign out_pkt   = out_pkt_q;
  assign skid_full = skid_valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC, single-outstanding imem request FSM and redirect kill.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
`ifdef FETCH_PERF_CNT_EN
  ,
  parameter int          PERF_W    = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_fetch_cnt,
  output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic        skid_full;
  logic        req_fire;
  logic        rsp_capture;
  fetch_pkt_t  rsp_pkt;
  fetch_pkt_t  id_pkt;

  // Gated by rst_n so no request is presented while reset is held.
  assign imem_req_valid = rst_n && (state_q == S_REQ) && !skid_full;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_capture    = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign rsp_pkt        = '{instr: imem_rsp_data, pc: infl_pc_q};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    infl_pc_d = infl_pc_q;
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
      // A fetch accepted now or still in flight belongs to the old path.
      case (state_q)
        S_REQ:   state_d = req_fire ? S_KILL : S_REQ;
        S_WAIT,
        S_KILL:  state_d = imem_rsp_valid ? S_REQ : S_KILL;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            infl_pc_d = pc_q;
            pc_d      = pc_q + 32'd4;
            state_d   = S_WAIT;
          end
        end
        S_WAIT:  if (imem_rsp_valid) state_d = S_REQ;
        S_KILL:  if (imem_rsp_valid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      infl_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  fetch_skid_buf #(
    .NOP_INSTR (NOP_INSTR)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .in_valid  (rsp_capture),
    .in_pkt    (rsp_pkt),
    .out_ready (id_ready),
    .out_valid (id_valid),
    .out_pkt   (id_pkt),
    .skid_full (skid_full)
  );

  assign id_instr = id_pkt.instr;
  assign id_pc    = id_pkt.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_W-1:0] perf_fetch_q, perf_fetch_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

  // Both counters saturate at all-ones.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (id_valid && id_ready && !(&perf_fetch_q))
      perf_fetch_d = perf_fetch_q + PERF_W'(1);
    if (id_valid && !id_ready && !(&perf_stall_q))
      perf_stall_d = perf_stall_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
